ac_ctrl: RTL and testbench

Multi-cycle sequencer for the accumulator and the shared data bus. It accepts one accumulator instruction at a time over a start/done handshake. It then drives the bus source select, the accumulator control strobes (write, increment, clear, ALU write-back), the ALU operation code and the destination-register write strobe, in a fixed per-opcode cycle sequence. It sits between the instruction decoder and the AC, ALU and register-file datapath.

---
 rtl/ac_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_ac_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ac_ctrl.sv
// Accumulator/bus sequencer: accepts one AC instruction per start/done handshake
// and plays out its fixed bus-select, AC-strobe and ALU-op cycle sequence.
module ac_ctrl #(
  parameter int unsigned AC_CODE = 5,
  parameter int unsigned ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic [3:0] operand,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] bus_sel,
  output logic [3:0] dst_sel,
  output logic       dst_we,
  output logic       ac_write_en,
  output logic       ac_inc_en,
  output logic       ac_clr_en,
  output logic       alu_to_ac,
  output logic [2:0] alu_op
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BUS  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0] OP_CLAC = 4'd1;
  localparam logic [3:0] OP_INAC = 4'd2;
  localparam logic [3:0] OP_LDAC = 4'd3;
  localparam logic [3:0] OP_STAC = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;

  localparam logic [3:0] AC_SEL   = 4'(AC_CODE);
  localparam logic [3:0] LAT_M1   = 4'(ALU_LAT - 1);
  localparam bit         HAS_WAIT = (ALU_LAT != 0);

  logic [2:0] state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [3:0] opd_q, opd_d;
  logic       ill_q, ill_d;
  logic [3:0] cnt_q, cnt_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [3:0] bus_sel_q, bus_sel_d;
  logic [3:0] dst_sel_q, dst_sel_d;
  logic       dst_we_q, dst_we_d;
  logic       ac_write_en_q, ac_write_en_d;
  logic       ac_inc_en_q, ac_inc_en_d;
  logic       ac_clr_en_q, ac_clr_en_d;
  logic       alu_to_ac_q, alu_to_ac_d;
  logic [2:0] alu_op_q, alu_op_d;

  logic       illegal_in;
  logic       alu_cur;
  logic       alu_nxt;
  logic [3:0] src_nxt;
  logic [2:0] code_nxt;

  // Next state plus output decode; outputs are decoded from the upcoming state so they register cleanly
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    opd_d         = opd_q;
    ill_d         = ill_q;
    cnt_d         = cnt_q;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    bus_sel_d     = 4'd0;
    dst_sel_d     = 4'd0;
    dst_we_d      = 1'b0;
    ac_write_en_d = 1'b0;
    ac_inc_en_d   = 1'b0;
    ac_clr_en_d   = 1'b0;
    alu_to_ac_d   = 1'b0;
    alu_op_d      = 3'd0;

    // A store back into the AC itself is rejected at accept time
    illegal_in = opcode[3] || ((opcode == OP_STAC) && (operand == AC_SEL));
    alu_cur    = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = opcode;
          opd_d = operand;
          ill_d = illegal_in;
          if (illegal_in) begin
            state_d = S_DONE;
          end else begin
            case (opcode)
              OP_CLAC, OP_INAC:                        state_d = S_EXEC;
              OP_LDAC, OP_STAC, OP_ADD, OP_SUB, OP_MUL: state_d = S_BUS;
              default:                                 state_d = S_DONE;
            endcase
          end
        end
      end
      S_BUS: begin
        if (alu_cur && HAS_WAIT) begin
          state_d = S_WAIT;
          cnt_d   = LAT_M1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_EXEC;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_EXEC:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    alu_nxt  = (op_d == OP_ADD) || (op_d == OP_SUB) || (op_d == OP_MUL);
    src_nxt  = (op_d == OP_STAC) ? AC_SEL : opd_d;
    code_nxt = alu_nxt ? 3'(op_d - 4'd4) : 3'd0;
    busy_d   = (state_d != S_IDLE);

    case (state_d)
      S_BUS, S_WAIT: begin
        bus_sel_d = src_nxt;
        alu_op_d  = code_nxt;
      end
      S_EXEC: begin
        case (op_d)
          OP_CLAC: ac_clr_en_d = 1'b1;
          OP_INAC: ac_inc_en_d = 1'b1;
          OP_LDAC: begin
            bus_sel_d     = src_nxt;
            ac_write_en_d = 1'b1;
          end
          OP_STAC: begin
            bus_sel_d = AC_SEL;
            dst_sel_d = opd_d;
            dst_we_d  = 1'b1;
          end
          OP_ADD, OP_SUB, OP_MUL: begin
            bus_sel_d   = src_nxt;
            alu_op_d    = code_nxt;
            alu_to_ac_d = 1'b1;
          end
          default: ;
        endcase
      end
      S_DONE: begin
        done_d = 1'b1;
        err_d  = ill_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= 4'd0;
      opd_q         <= 4'd0;
      ill_q         <= 1'b0;
      cnt_q         <= 4'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      bus_sel_q     <= 4'd0;
      dst_sel_q     <= 4'd0;
      dst_we_q      <= 1'b0;
      ac_write_en_q <= 1'b0;
      ac_inc_en_q   <= 1'b0;
      ac_clr_en_q   <= 1'b0;
      alu_to_ac_q   <= 1'b0;
      alu_op_q      <= 3'd0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      opd_q         <= opd_d;
      ill_q         <= ill_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      bus_sel_q     <= bus_sel_d;
      dst_sel_q     <= dst_sel_d;
      dst_we_q      <= dst_we_d;
      ac_write_en_q <= ac_write_en_d;
      ac_inc_en_q   <= ac_inc_en_d;
      ac_clr_en_q   <= ac_clr_en_d;
      alu_to_ac_q   <= alu_to_ac_d;
      alu_op_q      <= alu_op_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign bus_sel     = bus_sel_q;
  assign dst_sel     = dst_sel_q;
  assign dst_we      = dst_we_q;
  assign ac_write_en = ac_write_en_q;
  assign ac_inc_en   = ac_inc_en_q;
  assign ac_clr_en   = ac_clr_en_q;
  assign alu_to_ac   = alu_to_ac_q;
  assign alu_op      = alu_op_q;

endmodule

// File: tb/tb_ac_ctrl.sv
// Bench for ac_ctrl: two instances (ALU_LAT=2 and 0) on shared stimulus, each
// compared every cycle against a per-instruction expected-output schedule.
module tb_ac_ctrl;

  localparam logic [3:0] AC = 4'd5;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] bus_sel;
    logic [3:0] dst_sel;
    logic       dst_we;
    logic       ac_write_en;
    logic       ac_inc_en;
    logic       ac_clr_en;
    logic       alu_to_ac;
    logic [2:0] alu_op;
  } outv_t;

  typedef outv_t sched_t[$];

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] opcode;
  logic [3:0] operand;

  logic       busy2, done2, err2, dst_we2, wr2, inc2, clr2, a2ac2;
  logic [3:0] bus2, dsel2;
  logic [2:0] aop2;
  logic       busy0, done0, err0, dst_we0, wr0, inc0, clr0, a2ac0;
  logic [3:0] bus0, dsel0;
  logic [2:0] aop0;

  ac_ctrl #(.AC_CODE(5), .ALU_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .operand(operand),
    .busy(busy2), .done(done2), .err(err2), .bus_sel(bus2), .dst_sel(dsel2),
    .dst_we(dst_we2), .ac_write_en(wr2), .ac_inc_en(inc2), .ac_clr_en(clr2),
    .alu_to_ac(a2ac2), .alu_op(aop2)
  );

  ac_ctrl #(.AC_CODE(5), .ALU_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .operand(operand),
    .busy(busy0), .done(done0), .err(err0), .bus_sel(bus0), .dst_sel(dsel0),
    .dst_we(dst_we0), .ac_write_en(wr0), .ac_inc_en(inc0), .ac_clr_en(clr0),
    .alu_to_ac(a2ac0), .alu_op(aop0)
  );

  outv_t got2, got0;
  assign got2 = '{busy2, done2, err2, bus2, dsel2, dst_we2, wr2, inc2, clr2, a2ac2, aop2};
  assign got0 = '{busy0, done0, err0, bus0, dsel0, dst_we0, wr0, inc0, clr0, a2ac0, aop0};

  int     n_tests;
  int     n_fail;
  bit     chk_en;
  sched_t q2, q0;
  outv_t  exp2, exp0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input outv_t got, input outv_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got busy=%b done=%b err=%b bus=%0d dsel=%0d we=%b wr=%b inc=%b clr=%b a2ac=%b aop=%0d | exp busy=%b done=%b err=%b bus=%0d dsel=%0d we=%b wr=%b inc=%b clr=%b a2ac=%b aop=%0d",
               tag, $time, got.busy, got.done, got.err, got.bus_sel, got.dst_sel, got.dst_we,
               got.ac_write_en, got.ac_inc_en, got.ac_clr_en, got.alu_to_ac, got.alu_op,
               exp.busy, exp.done, exp.err, exp.bus_sel, exp.dst_sel, exp.dst_we,
               exp.ac_write_en, exp.ac_inc_en, exp.ac_clr_en, exp.alu_to_ac, exp.alu_op);
    end
  endtask

  // Expected outputs for each cycle after acceptance, straight from the opcode table
  task automatic build(input logic [3:0] op, input logic [3:0] opd, input int lat, inout sched_t q);
    outv_t e, b;
    e = '0;
    e.busy = 1'b1;
    b = e;
    if (op >= 4'd8 || (op == 4'd4 && opd == AC)) begin
      e.done = 1'b1;
      e.err  = 1'b1;
      q.push_back(e);
      return;
    end
    case (op)
      4'd1: begin b.ac_clr_en = 1'b1; q.push_back(b); end
      4'd2: begin b.ac_inc_en = 1'b1; q.push_back(b); end
      4'd3: begin
        b.bus_sel = opd;        q.push_back(b);
        b.ac_write_en = 1'b1;   q.push_back(b);
      end
      4'd4: begin
        b.bus_sel = AC;         q.push_back(b);
        b.dst_sel = opd;
        b.dst_we  = 1'b1;       q.push_back(b);
      end
      4'd5, 4'd6, 4'd7: begin
        b.bus_sel = opd;
        b.alu_op  = (op == 4'd5) ? 3'd1 : (op == 4'd6) ? 3'd2 : 3'd3;
        for (int i = 0; i <= lat; i++) q.push_back(b);
        b.alu_to_ac = 1'b1;     q.push_back(b);
      end
      default: ;
    endcase
    e.done = 1'b1;
    q.push_back(e);
  endtask

  task automatic model_adv(input logic r, input logic s, input logic [3:0] o, input logic [3:0] d,
                           input int lat, inout sched_t q, inout outv_t cur);
    if (r) begin
      q.delete();
      cur = '0;
    end else begin
      if (!cur.busy && s) build(o, d, lat, q);
      cur = (q.size() > 0) ? q.pop_front() : outv_t'('0);
    end
  endtask

  // One clock cycle: drive, check on the falling edge, advance the model for the next edge
  task automatic step(input logic r, input logic s, input logic [3:0] o, input logic [3:0] d);
    rst = r; start = s; opcode = o; operand = d;
    @(negedge clk);
    if (chk_en) begin
      check("lat2", got2, exp2);
      check("lat0", got0, exp0);
    end
    model_adv(r, s, o, d, 2, q2, exp2);
    model_adv(r, s, o, d, 0, q0, exp0);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    exp2    = '0;
    exp0    = '0;
    rst = 1'b1; start = 1'b0; opcode = 4'd0; operand = 4'd0;
    @(posedge clk);
    #1;

    // Reset held with an INAC request, then directed sequences
    step(1'b1, 1'b1, 4'd2, 4'd0);
    step(1'b1, 1'b1, 4'd2, 4'd0);
    idle(2);
    step(1'b0, 1'b1, 4'd3, 4'd13); idle(6);
    step(1'b0, 1'b1, 4'd7, 4'd3);  idle(8);
    step(1'b0, 1'b1, 4'd4, 4'd7);  idle(5);
    step(1'b0, 1'b1, 4'd4, 4'd5);  idle(3);
    step(1'b0, 1'b1, 4'd12, 4'd1); idle(1);
    step(1'b0, 1'b1, 4'd1, 4'd0);  idle(4);
    step(1'b0, 1'b1, 4'd3, 4'd5);  idle(5);
    step(1'b0, 1'b1, 4'd5, 4'd9);
    step(1'b0, 1'b1, 4'd2, 4'd0);
    idle(8);
    step(1'b0, 1'b1, 4'd6, 4'd2);
    step(1'b0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 4'd0, 4'd0);
    idle(5);
    // Back-to-back starts with everything else randomized
    for (int i = 0; i < 3000; i++) begin
      logic       r, s;
      logic [3:0] o, d;
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 2) != 0);
      o = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      d = ($urandom_range(0, 3) == 0) ? AC : 4'($urandom_range(0, 15));
      step(r, s, o, d);
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
